// File: rtl/fb_rect_fill_pkg.sv
// Shared defaults, state encoding and small helpers for the rectangle-fill engine.
package fb_rect_fill_pkg;

    localparam int DEF_H_RES   = 480;
    localparam int DEF_V_RES   = 272;
    localparam int DEF_ADDR_W  = 17;
    localparam int DEF_COLOR_W = 24;

    localparam int CMD_W  = 11;
    localparam int CLIP_W = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [CLIP_W-1:0] min_clip(input logic [CLIP_W-1:0] a,
                                                   input logic [CLIP_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fb_clip.sv
// Clips a registered rectangle command to the panel and flags commands that draw nothing.
module fb_clip
    import fb_rect_fill_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES
) (
    input  logic [CMD_W-1:0]  x,
    input  logic [CMD_W-1:0]  y,
    input  logic [CMD_W-1:0]  w,
    input  logic [CMD_W-1:0]  h,
    output logic [CLIP_W-1:0] x1,
    output logic [CLIP_W-1:0] y1,
    output logic              empty
);

    localparam logic [CLIP_W-1:0] HMAX = CLIP_W'(H_RES);
    localparam logic [CLIP_W-1:0] VMAX = CLIP_W'(V_RES);

    logic [CLIP_W-1:0] x_end;
    logic [CLIP_W-1:0] y_end;

    // One extra bit keeps x+w and y+h from wrapping before the clamp.
    always_comb begin
        x_end = {1'b0, x} + {1'b0, w};
        y_end = {1'b0, y} + {1'b0, h};
        x1    = min_clip(x_end, HMAX);
        y1    = min_clip(y_end, VMAX);
        empty = (w == '0) || (h == '0) || ({1'b0, x} >= HMAX) || ({1'b0, y} >= VMAX);
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: accepts one command, clips it, and writes one framebuffer pixel per clock.
module fb_rect_fill
    import fb_rect_fill_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [10:0]        cmd_x,
    input  logic [10:0]        cmd_y,
    input  logic [10:0]        cmd_w,
    input  logic [10:0]        cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               fb_ena,
    output logic               fb_wea,
    output logic [ADDR_W-1:0]  fb_addra,
    output logic [COLOR_W-1:0] fb_dina,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_RES);

    logic [1:0]         state_q, state_d;
    logic [CMD_W-1:0]   x_q, x_d;
    logic [CMD_W-1:0]   y_q, y_d;
    logic [CMD_W-1:0]   w_q, w_d;
    logic [CMD_W-1:0]   h_q, h_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [CLIP_W-1:0]  col_q, col_d;
    logic [CLIP_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               fb_ena_q, fb_ena_d;
    logic [ADDR_W-1:0]  fb_addra_q, fb_addra_d;
    logic [COLOR_W-1:0] fb_dina_q, fb_dina_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CLIP_W-1:0]  x1;
    logic [CLIP_W-1:0]  y1;
    logic               empty;
    logic               accept;
    logic               row_end;

    fb_clip #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_clip (
        .x     (x_q),
        .y     (y_q),
        .w     (w_q),
        .h     (h_q),
        .x1    (x1),
        .y1    (y1),
        .empty (empty)
    );

    assign accept  = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
    assign row_end = (col_q == (x1 - 12'd1));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (empty) begin
                    state_d = ST_DONE;
                end else begin
                    row_base_d = ADDR_W'(y_q) * H_STRIDE;
                    col_d      = {1'b0, x_q};
                    row_d      = {1'b0, y_q};
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (row_end) begin
                    col_d      = {1'b0, x_q};
                    row_d      = row_q + 12'd1;
                    row_base_d = row_base_q + H_STRIDE;
                    if (row_q == (y1 - 12'd1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    col_d = col_q + 12'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so every output lags the FSM by one cycle.
    always_comb begin
        cmd_ready_d = (state_q == ST_IDLE) && !accept;
        fb_ena_d    = (state_q == ST_FILL);
        fb_addra_d  = '0;
        fb_dina_d   = '0;
        if (state_q == ST_FILL) begin
            fb_addra_d = row_base_q + ADDR_W'(col_q);
            fb_dina_d  = color_q;
        end
        busy_d = accept || (state_q != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            cmd_ready_q <= 1'b0;
            fb_ena_q    <= 1'b0;
            fb_addra_q  <= '0;
            fb_dina_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            cmd_ready_q <= cmd_ready_d;
            fb_ena_q    <= fb_ena_d;
            fb_addra_q  <= fb_addra_d;
            fb_dina_q   <= fb_dina_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign fb_ena    = fb_ena_q;
    assign fb_wea    = fb_ena_q;
    assign fb_addra  = fb_addra_q;
    assign fb_dina   = fb_dina_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
